soc_domain_seq: RTL and testbench

- Parametrised N-domain clock/reset sequencer. It is the next-generation replacement for the fixed per-domain clock-enable and reset register bits in the SoC control block.
- Per domain, it turns a software on/off request plus a PLL-lock indication into correctly ordered clock-enable and active-low reset outputs.
- It adds lock timeout and lock-loss detection, plus an optional ordered power-up mode.
- It sits between the SoC control register file (req, lock status) and the core, link and peripheral domains.

---
 rtl/soc_domain_seq_if.sv | 47 ++++
 rtl/soc_domain_seq.sv | 191 +++++++++++++++++++
 tb/tb_soc_domain_seq.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_domain_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : soc_domain_seq_if                                             |
// | Purpose  : Bundle of the per-domain request/lock inputs and the          |
// |            clock-enable/reset/status outputs of soc_domain_seq.          |
// | Signals  : req_i        - per-domain on/off request (level)              |
// |            pll_locked_i - per-domain clock-source lock                   |
// |            clk_en_o     - per-domain clock-gate enable                   |
// |            arst_n_o     - per-domain active-low reset                    |
// |            on_o         - domain fully ON                                |
// |            err_o        - domain in error (sticky until req drops)       |
// |            busy_o       - any domain in a transitional state             |
// | Modports : master (control/register side), slave (sequencer side)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface soc_domain_seq_if #(
   parameter int N_DOM = 4
) ();
   logic [N_DOM-1:0] req_i;
   logic [N_DOM-1:0] pll_locked_i;
   logic [N_DOM-1:0] clk_en_o;
   logic [N_DOM-1:0] arst_n_o;
   logic [N_DOM-1:0] on_o;
   logic [N_DOM-1:0] err_o;
   logic             busy_o;

   modport master (
      output req_i,
      output pll_locked_i,
      input  clk_en_o,
      input  arst_n_o,
      input  on_o,
      input  err_o,
      input  busy_o
   );

   modport slave (
      input  req_i,
      input  pll_locked_i,
      output clk_en_o,
      output arst_n_o,
      output on_o,
      output err_o,
      output busy_o
   );
endinterface
`default_nettype wire

// File: rtl/soc_domain_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : soc_domain_seq                                                |
// | Purpose  : N-domain clock/reset sequencer. Each domain runs its own      |
// |            Moore FSM (OFF, WLOCK, RSTHOLD, ON, PDRST, ERR) that turns a  |
// |            software request and a PLL-lock flag into ordered clock       |
// |            enable and active-low reset, with lock timeout, lock-loss     |
// |            detection and an optional index-ordered power-up.             |
// | Ports    : clk_i  - sequencer clock                                      |
// |            arst_i - asynchronous active-high reset                       |
// |            bus    - soc_domain_seq_if.slave (req/lock in, status out)    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module soc_domain_seq #(
   parameter int N_DOM        = 4,
   parameter int CNT_W        = 10,
   parameter int RST_HOLD     = 16,
   parameter int LOCK_TIMEOUT = 512,
   parameter int SEQ_ORDERED  = 0
) (
   input  logic                 clk_i,
   input  logic                 arst_i,
   soc_domain_seq_if.slave      bus
);

   // ---------------------------------------------------------------------
   // Elaboration-time parameter range checks
   // ---------------------------------------------------------------------
   if (N_DOM < 1 || N_DOM > 32) begin : g_chk_n_dom
      $error("soc_domain_seq: N_DOM must be in 1..32");
   end
   if (CNT_W < 1 || CNT_W > 31) begin : g_chk_cnt_w
      $error("soc_domain_seq: CNT_W must be in 1..31");
   end
   if (RST_HOLD < 1 || RST_HOLD > (2**CNT_W) - 1) begin : g_chk_rst_hold
      $error("soc_domain_seq: RST_HOLD must be in 1..2^CNT_W-1");
   end
   if (LOCK_TIMEOUT < 0 || LOCK_TIMEOUT >= (2**CNT_W)) begin : g_chk_timeout
      $error("soc_domain_seq: LOCK_TIMEOUT must be < 2^CNT_W");
   end
   if (SEQ_ORDERED != 0 && SEQ_ORDERED != 1) begin : g_chk_ordered
      $error("soc_domain_seq: SEQ_ORDERED must be 0 or 1");
   end

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_WLOCK   = 3'd1,
      ST_RSTHOLD = 3'd2,
      ST_ON      = 3'd3,
      ST_PDRST   = 3'd4,
      ST_ERR     = 3'd5
   } state_t;

   // Terminal counts. With the timeout disabled c_to_last is never used.
   localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic             c_to_en     = (LOCK_TIMEOUT != 0);
   localparam logic             c_ordered   = (SEQ_ORDERED != 0);

   logic [N_DOM-1:0] w_on;
   logic [N_DOM-1:0] w_busy;
   // w_ord_ok[i]: every requested domain below i is already ON.
   logic [N_DOM-1:0] w_ord_ok;

   for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom
      state_t           r_state;
      state_t           w_nxt_state;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_nxt_cnt;
      logic             r_clk_en;
      logic             r_arst_n;
      logic             r_on;
      logic             r_err;
      logic             r_busy;
      logic             w_go;

      // Order chain uses the registered ON flag of the lower domain, so a
      // higher domain leaves WLOCK one edge after the lower on_o rises.
      if (gi == 0) begin : g_ord_first
         assign w_ord_ok[gi] = 1'b1;
      end else begin : g_ord_chain
         assign w_ord_ok[gi] = w_ord_ok[gi-1] & (~bus.req_i[gi-1] | w_on[gi-1]);
      end

      assign w_go = bus.pll_locked_i[gi] & (~c_ordered | w_ord_ok[gi]);

      always_comb begin
         w_nxt_state = r_state;
         w_nxt_cnt   = r_cnt;
         case (r_state)
            ST_OFF: begin
               if (bus.req_i[gi]) begin
                  w_nxt_state = ST_WLOCK;
                  w_nxt_cnt   = '0;
               end
            end
            ST_WLOCK: begin
               if (!bus.req_i[gi]) begin
                  w_nxt_state = ST_OFF;
                  w_nxt_cnt   = '0;
               end else if (w_go) begin
                  w_nxt_state = ST_RSTHOLD;
                  w_nxt_cnt   = '0;
               end else if (c_to_en && r_cnt == c_to_last) begin
                  w_nxt_state = ST_ERR;
               end else if (c_to_en) begin
                  // Counter only advances when it can reach a terminal
                  // compare; with no timeout it parks instead of wrapping.
                  w_nxt_cnt = r_cnt + CNT_W'(1);
               end
            end
            ST_RSTHOLD: begin
               if (!bus.req_i[gi]) begin
                  w_nxt_state = ST_OFF;
                  w_nxt_cnt   = '0;
               end else if (!bus.pll_locked_i[gi]) begin
                  w_nxt_state = ST_ERR;
               end else if (r_cnt == c_hold_last) begin
                  w_nxt_state = ST_ON;
               end else begin
                  w_nxt_cnt = r_cnt + CNT_W'(1);
               end
            end
            ST_ON: begin
               // Lock loss wins over a simultaneous request drop.
               if (!bus.pll_locked_i[gi]) begin
                  w_nxt_state = ST_ERR;
               end else if (!bus.req_i[gi]) begin
                  w_nxt_state = ST_PDRST;
                  w_nxt_cnt   = '0;
               end
            end
            ST_PDRST: begin
               // Power-down always completes so the domain sees a full
               // clocked reset before its clock is gated.
               if (r_cnt == c_hold_last) begin
                  w_nxt_state = ST_OFF;
                  w_nxt_cnt   = '0;
               end else begin
                  w_nxt_cnt = r_cnt + CNT_W'(1);
               end
            end
            ST_ERR: begin
               if (!bus.req_i[gi]) begin
                  w_nxt_state = ST_OFF;
                  w_nxt_cnt   = '0;
               end
            end
            default: begin
               w_nxt_state = ST_OFF;
               w_nxt_cnt   = '0;
            end
         endcase
      end

      // Outputs are registered from the next state, so they are exactly the
      // Moore decode of r_state with no path from inputs.
      always_ff @(posedge clk_i or posedge arst_i) begin
         if (arst_i) begin
            r_state  <= ST_OFF;
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_arst_n <= 1'b0;
            r_on     <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_clk_en <= (w_nxt_state == ST_RSTHOLD) || (w_nxt_state == ST_ON) ||
                        (w_nxt_state == ST_PDRST);
            r_arst_n <= (w_nxt_state == ST_ON);
            r_on     <= (w_nxt_state == ST_ON);
            r_err    <= (w_nxt_state == ST_ERR);
            r_busy   <= (w_nxt_state == ST_WLOCK) || (w_nxt_state == ST_RSTHOLD) ||
                        (w_nxt_state == ST_PDRST);
         end
      end

      assign bus.clk_en_o[gi] = r_clk_en;
      assign bus.arst_n_o[gi] = r_arst_n;
      assign bus.on_o[gi]     = r_on;
      assign bus.err_o[gi]    = r_err;
      assign w_on[gi]         = r_on;
      assign w_busy[gi]       = r_busy;
   end

   assign bus.busy_o = |w_busy;

endmodule
`default_nettype wire

// File: tb/tb_soc_domain_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_soc_domain_seq                                             |
// | Purpose  : Directed bench for soc_domain_seq. dut_a is unordered with a  |
// |            512-cycle lock timeout; dut_b is ordered with no timeout.     |
// |            Expected output bits are queued with the edge they are due   |
// |            at and compared when that edge has passed.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_soc_domain_seq;

   localparam int S_CE = 0;
   localparam int S_RN = 1;
   localparam int S_ON = 2;
   localparam int S_ER = 3;
   localparam int S_BZ = 4;

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   soc_domain_seq_if #(.N_DOM(4)) bus_a ();
   soc_domain_seq_if #(.N_DOM(4)) bus_b ();

   soc_domain_seq #(
      .N_DOM(4), .CNT_W(10), .RST_HOLD(16), .LOCK_TIMEOUT(512), .SEQ_ORDERED(0)
   ) dut_a (
      .clk_i (clk),
      .arst_i(arst),
      .bus   (bus_a.slave)
   );

   soc_domain_seq #(
      .N_DOM(4), .CNT_W(10), .RST_HOLD(16), .LOCK_TIMEOUT(0), .SEQ_ORDERED(1)
   ) dut_b (
      .clk_i (clk),
      .arst_i(arst),
      .bus   (bus_b.slave)
   );

   typedef struct {
      int    cyc;
      int    d;
      int    sel;
      int    idx;
      logic  exp;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_tests;
   int   n_fail;

   function automatic logic obs(int d, int sel, int idx);
      logic [3:0] v;
      v = '0;
      case (sel)
         S_CE:    v = (d != 0) ? bus_b.clk_en_o : bus_a.clk_en_o;
         S_RN:    v = (d != 0) ? bus_b.arst_n_o : bus_a.arst_n_o;
         S_ON:    v = (d != 0) ? bus_b.on_o     : bus_a.on_o;
         S_ER:    v = (d != 0) ? bus_b.err_o    : bus_a.err_o;
         S_BZ:    v = {3'b000, ((d != 0) ? bus_b.busy_o : bus_a.busy_o)};
         default: v = '0;
      endcase
      return v[idx];
   endfunction

   function automatic logic [31:0] all_out(int d);
      if (d != 0)
         return {15'd0, bus_b.clk_en_o, bus_b.arst_n_o, bus_b.on_o, bus_b.err_o, bus_b.busy_o};
      return {15'd0, bus_a.clk_en_o, bus_a.arst_n_o, bus_a.on_o, bus_a.err_o, bus_a.busy_o};
   endfunction

   task automatic exp_at(int c, int d, int sel, int idx, logic e, string tag);
      exp_t x;
      x.cyc = c; x.d = d; x.sel = sel; x.idx = idx; x.exp = e; x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      n_tests++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // One clock edge: sample 2 time units after it, then compare every
   // queued expectation that is now due.
   task automatic tick();
      exp_t x;
      exp_t keep[$];
      logic o;
      @(posedge clk);
      #2;
      cyc++;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         if (x.cyc <= cyc) begin
            o = obs(x.d, x.sel, x.idx);
            n_tests++;
            assert (o === x.exp) else begin
               n_fail++;
               $error("FAIL %s (cyc %0d): observed %b expected %b", x.tag, cyc, o, x.exp);
            end
         end else begin
            keep.push_back(x);
         end
      end
      sb = keep;
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int m;
      int l;
      cyc     = 0;
      n_tests = 0;
      n_fail  = 0;
      arst    = 1'b1;
      bus_a.req_i        = '0;
      bus_a.pll_locked_i = '1;
      bus_b.req_i        = '0;
      bus_b.pll_locked_i = '1;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #2;
      chk("reset_a", all_out(0), 32'd0);
      chk("reset_b", all_out(1), 32'd0);
      arst = 1'b0;

      // ---------------- basic power-up / power-down, domain 2 ----------
      bus_a.req_i[2] = 1'b1;
      k = cyc + 1;
      exp_at(k,      0, S_CE, 2, 1'b0, "pu_ce_wlock");
      exp_at(k,      0, S_BZ, 0, 1'b1, "pu_busy_wlock");
      exp_at(k + 1,  0, S_CE, 2, 1'b1, "pu_ce_rise");
      exp_at(k + 16, 0, S_RN, 2, 1'b0, "pu_rstn_hold");
      exp_at(k + 16, 0, S_ON, 2, 1'b0, "pu_on_hold");
      exp_at(k + 16, 0, S_BZ, 0, 1'b1, "pu_busy_hold");
      exp_at(k + 17, 0, S_RN, 2, 1'b1, "pu_rstn_rise");
      exp_at(k + 17, 0, S_ON, 2, 1'b1, "pu_on_rise");
      exp_at(k + 17, 0, S_BZ, 0, 1'b0, "pu_busy_clear");
      exp_at(k + 17, 0, S_CE, 0, 1'b0, "pu_other_dom");
      run(25);
      bus_a.req_i[2] = 1'b0;
      m = cyc + 1;
      exp_at(m,      0, S_RN, 2, 1'b0, "pd_rstn_fall");
      exp_at(m,      0, S_ON, 2, 1'b0, "pd_on_fall");
      exp_at(m,      0, S_BZ, 0, 1'b1, "pd_busy");
      exp_at(m + 15, 0, S_CE, 2, 1'b1, "pd_ce_held");
      exp_at(m + 15, 0, S_BZ, 0, 1'b1, "pd_busy_end");
      exp_at(m + 16, 0, S_CE, 2, 1'b0, "pd_ce_fall");
      exp_at(m + 16, 0, S_BZ, 0, 1'b0, "pd_busy_clear");
      run(20);

      // ---------------- lock timeout, domain 0 ----------------
      bus_a.pll_locked_i[0] = 1'b0;
      bus_a.req_i[0]        = 1'b1;
      k = cyc + 1;
      exp_at(k + 511, 0, S_ER, 0, 1'b0, "to_err_early");
      exp_at(k + 511, 0, S_BZ, 0, 1'b1, "to_busy_wlock");
      exp_at(k + 512, 0, S_ER, 0, 1'b1, "to_err_set");
      exp_at(k + 512, 0, S_CE, 0, 1'b0, "to_ce_gated");
      exp_at(k + 512, 0, S_BZ, 0, 1'b0, "to_busy_err");
      run(515);
      bus_a.req_i[0] = 1'b0;
      m = cyc + 1;
      exp_at(m, 0, S_ER, 0, 1'b0, "to_err_clear");
      run(3);
      bus_a.pll_locked_i[0] = 1'b1;

      // ---------------- lock loss in ON, domain 1 ----------------
      bus_a.req_i = 4'b1111;
      k = cyc + 1;
      for (int i = 0; i < 4; i++) exp_at(k + 17, 0, S_ON, i, 1'b1, "all_on");
      run(20);
      bus_a.pll_locked_i[1] = 1'b0;
      l = cyc + 1;
      exp_at(l,     0, S_CE, 1, 1'b0, "ll_ce");
      exp_at(l,     0, S_RN, 1, 1'b0, "ll_rstn");
      exp_at(l,     0, S_ER, 1, 1'b1, "ll_err");
      exp_at(l,     0, S_ON, 0, 1'b1, "ll_dom0_on");
      exp_at(l,     0, S_ON, 2, 1'b1, "ll_dom2_on");
      exp_at(l,     0, S_ON, 3, 1'b1, "ll_dom3_on");
      exp_at(l + 3, 0, S_ER, 1, 1'b1, "ll_err_sticky");
      tick();
      bus_a.pll_locked_i[1] = 1'b1;
      run(3);
      bus_a.req_i[1] = 1'b0;
      m = cyc + 1;
      exp_at(m, 0, S_ER, 1, 1'b0, "ll_err_clear");
      run(2);

      // ---------------- lock loss + req drop in same ON cycle ----------
      bus_a.req_i[1] = 1'b1;
      k = cyc + 1;
      exp_at(k + 17, 0, S_ON, 1, 1'b1, "re_on");
      run(20);
      bus_a.req_i[1]        = 1'b0;
      bus_a.pll_locked_i[1] = 1'b0;
      l = cyc + 1;
      exp_at(l,     0, S_ER, 1, 1'b1, "sim_err_wins");
      exp_at(l,     0, S_BZ, 0, 1'b0, "sim_not_pdrst");
      exp_at(l + 1, 0, S_ER, 1, 1'b0, "sim_err_exit");
      tick();
      bus_a.pll_locked_i[1] = 1'b1;
      run(2);

      // ---------------- req drop in RSTHOLD, domain 1 ----------------
      bus_a.req_i[1] = 1'b1;
      k = cyc + 1;
      exp_at(k + 4, 0, S_CE, 1, 1'b1, "rh_ce_on");
      run(5);
      bus_a.req_i[1] = 1'b0;
      m = cyc + 1;
      exp_at(m, 0, S_CE, 1, 1'b0, "rh_drop_ce");
      exp_at(m, 0, S_BZ, 0, 1'b0, "rh_drop_off");
      run(3);

      // ---------------- re-request during PDRST, domain 2 ----------------
      bus_a.req_i[2] = 1'b0;
      m = cyc + 1;
      exp_at(m + 15, 0, S_CE, 2, 1'b1, "rr_pdrst_runs");
      exp_at(m + 16, 0, S_CE, 2, 1'b0, "rr_off_ce");
      exp_at(m + 16, 0, S_BZ, 0, 1'b0, "rr_off_cycle");
      exp_at(m + 17, 0, S_CE, 2, 1'b0, "rr_wlock_ce");
      exp_at(m + 17, 0, S_BZ, 0, 1'b1, "rr_wlock_busy");
      exp_at(m + 18, 0, S_CE, 2, 1'b1, "rr_rsthold_ce");
      exp_at(m + 33, 0, S_ON, 2, 1'b0, "rr_on_early");
      exp_at(m + 34, 0, S_ON, 2, 1'b1, "rr_on");
      run(5);
      bus_a.req_i[2] = 1'b1;
      run(40);

      // ---------------- async reset during RSTHOLD ----------------
      bus_a.req_i = 4'b0000;
      run(20);
      bus_a.req_i = 4'b1111;
      run(5);
      chk("pre_arst_ce", 32'(bus_a.clk_en_o), 32'hf);
      #3;
      arst = 1'b1;
      #1;
      chk("arst_rsthold_a", all_out(0), 32'd0);
      tick();
      tick();
      arst = 1'b0;
      k = cyc + 1;
      exp_at(k,      0, S_CE, 3, 1'b0, "rst_re_wlock");
      exp_at(k,      0, S_BZ, 0, 1'b1, "rst_re_busy");
      exp_at(k + 1,  0, S_CE, 3, 1'b1, "rst_re_ce");
      exp_at(k + 16, 0, S_ON, 3, 1'b0, "rst_re_on_early");
      exp_at(k + 17, 0, S_ON, 3, 1'b1, "rst_re_on");
      run(25);

      // ---------------- async reset during PDRST ----------------
      bus_a.req_i[0] = 1'b0;
      run(4);
      chk("pre_arst_pd", 32'({bus_a.clk_en_o[0], bus_a.arst_n_o[0]}), 32'h2);
      #3;
      arst = 1'b1;
      #1;
      chk("arst_pdrst_a", all_out(0), 32'd0);
      tick();
      tick();
      arst = 1'b0;
      k = cyc + 1;
      exp_at(k + 1,  0, S_CE, 1, 1'b1, "rst2_ce1");
      exp_at(k + 1,  0, S_CE, 0, 1'b0, "rst2_ce0_off");
      exp_at(k + 17, 0, S_ON, 3, 1'b1, "rst2_on3");
      run(20);
      bus_a.req_i = 4'b0000;

      // ---------------- ordered mode, dut_b ----------------
      bus_b.pll_locked_i = 4'b1110;
      bus_b.req_i        = 4'b1111;
      k = cyc + 1;
      exp_at(k + 49,  1, S_BZ, 0, 1'b1, "ord_busy_wait");
      exp_at(k + 49,  1, S_CE, 3, 1'b0, "ord_d3_blocked");
      exp_at(k + 65,  1, S_ON, 0, 1'b0, "ord_on0_early");
      exp_at(k + 66,  1, S_ON, 0, 1'b1, "ord_on0");
      exp_at(k + 66,  1, S_CE, 1, 1'b0, "ord_ce1_wait");
      exp_at(k + 67,  1, S_CE, 1, 1'b1, "ord_ce1");
      exp_at(k + 82,  1, S_ON, 1, 1'b0, "ord_on1_early");
      exp_at(k + 83,  1, S_ON, 1, 1'b1, "ord_on1");
      exp_at(k + 83,  1, S_CE, 2, 1'b0, "ord_ce2_wait");
      exp_at(k + 84,  1, S_CE, 2, 1'b1, "ord_ce2");
      exp_at(k + 116, 1, S_ON, 3, 1'b0, "ord_on3_early");
      exp_at(k + 117, 1, S_ON, 3, 1'b1, "ord_on3");
      run(50);
      bus_b.pll_locked_i[0] = 1'b1;
      run(75);
      bus_b.req_i = 4'b0000;
      run(20);

      bus_b.req_i = 4'b1010;
      k = cyc + 1;
      exp_at(k + 1,  1, S_CE, 1, 1'b1, "ord2_ce1");
      exp_at(k + 17, 1, S_ON, 1, 1'b1, "ord2_on1");
      exp_at(k + 17, 1, S_CE, 3, 1'b0, "ord2_ce3_wait");
      exp_at(k + 18, 1, S_CE, 3, 1'b1, "ord2_ce3");
      exp_at(k + 18, 1, S_CE, 2, 1'b0, "ord2_ce2_off");
      exp_at(k + 33, 1, S_ON, 3, 1'b0, "ord2_on3_early");
      exp_at(k + 34, 1, S_ON, 3, 1'b1, "ord2_on3");
      run(40);
      bus_b.req_i = 4'b0000;
      run(20);

      // ---------------- timeout disabled, dut_b ----------------
      bus_b.pll_locked_i[0] = 1'b0;
      bus_b.req_i[0]        = 1'b1;
      k = cyc + 1;
      exp_at(k + 600,  1, S_ER, 0, 1'b0, "nto_err_600");
      exp_at(k + 2000, 1, S_ER, 0, 1'b0, "nto_err_2000");
      exp_at(k + 2000, 1, S_BZ, 0, 1'b1, "nto_busy");
      run(2001);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
